// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM bus arbiter: state encoding, fetch lane mask
// and default tuning values.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      IF_ACCESS,
      MEM_ACCESS,
      RESPOND
   } arb_state_t;

   localparam logic [3:0] FETCH_BYTE_SELECT = 4'b1111;

   localparam int DEFAULT_MAX_DATA_BURST = 4;
   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Bus watchdog: counts access cycles from the grant and flags an access that has
// been outstanding for TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 disables it.
module bus_watchdog
   import bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic done,
   output logic timeout
);

   localparam int COUNT_WIDTH = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);

   logic [COUNT_WIDTH-1:0] count;
   logic                   running;

   // The count reads 1 in the first access cycle, so the abort lands in access cycle N.
   always_ff @(posedge clock) begin
      if (reset) begin
         count   <= '0;
         running <= 1'b0;
      end else if (start) begin
         count   <= COUNT_WIDTH'(1);
         running <= 1'b1;
      end else if (done) begin
         count   <= '0;
         running <= 1'b0;
      end else if (running && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign timeout = (TIMEOUT_CYCLES != 0) && running && (count == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and data accesses,
// with data-first priority, bounded fetch starvation and a watchdog abort.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int MAX_DATA_BURST = DEFAULT_MAX_DATA_BURST,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_request,
   input  logic [31:0] if_address,
   output logic        if_ready,
   output logic [31:0] if_data,
   input  logic        mem_request,
   input  logic        mem_write_enable,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_write_data,
   input  logic [3:0]  mem_byte_select,
   output logic        mem_ready,
   output logic [31:0] mem_read_data,
   output logic        bus_chip_enable,
   output logic        bus_write_enable,
   output logic [31:0] bus_address,
   output logic [31:0] bus_write_data,
   output logic [3:0]  bus_byte_select,
   input  logic [31:0] bus_read_data,
   input  logic        bus_ready,
   output logic        stall_request,
   output logic        bus_error
);

   localparam int BURST_WIDTH = $clog2(MAX_DATA_BURST + 1);
   localparam logic [BURST_WIDTH-1:0] BURST_LIMIT = BURST_WIDTH'(MAX_DATA_BURST);

   arb_state_t             state;
   arb_state_t             next_state;
   logic [BURST_WIDTH-1:0] data_burst;
   logic                   grant_fetch;
   logic                   grant_data;
   logic                   access_done;
   logic                   timeout;
   logic                   served_fetch;
   logic [31:0]            response_data;

   bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock  (clock),
      .reset  (reset),
      .start  (grant_fetch | grant_data),
      .done   (access_done),
      .timeout(timeout)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Data wins a tie unless fetch has already waited through a full data burst.
   always_comb begin
      next_state  = state;
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      access_done = 1'b0;
      case (state)
         IDLE: begin
            if (mem_request && (!if_request || (data_burst != BURST_LIMIT))) begin
               grant_data = 1'b1;
               next_state = MEM_ACCESS;
            end else if (if_request) begin
               grant_fetch = 1'b1;
               next_state  = IF_ACCESS;
            end
         end
         IF_ACCESS, MEM_ACCESS: begin
            if (bus_ready || timeout) begin
               access_done = 1'b1;
               next_state  = RESPOND;
            end
         end
         RESPOND: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Bus outputs are latched at the grant and cleared when the access ends; a
   // coincident bus_ready takes precedence over the watchdog.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus_chip_enable  <= 1'b0;
         bus_write_enable <= 1'b0;
         bus_address      <= '0;
         bus_write_data   <= '0;
         bus_byte_select  <= '0;
         served_fetch     <= 1'b0;
         response_data    <= '0;
         bus_error        <= 1'b0;
         data_burst       <= '0;
      end else begin
         if (grant_data || grant_fetch) begin
            bus_chip_enable  <= 1'b1;
            bus_write_enable <= grant_data && mem_write_enable;
            bus_address      <= grant_data ? mem_address : if_address;
            bus_write_data   <= (grant_data && mem_write_enable) ? mem_write_data : '0;
            bus_byte_select  <= grant_data ? mem_byte_select : FETCH_BYTE_SELECT;
            served_fetch     <= grant_fetch;
         end else if (access_done) begin
            bus_chip_enable  <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_address      <= '0;
            bus_write_data   <= '0;
            bus_byte_select  <= '0;
            response_data    <= (bus_ready && !bus_write_enable) ? bus_read_data : '0;
            if (!bus_ready) begin
               bus_error <= 1'b1;
            end
         end

         if (grant_fetch) begin
            data_burst <= '0;
         end else if (grant_data) begin
            if (!if_request) begin
               data_burst <= '0;
            end else if (data_burst != BURST_LIMIT) begin
               data_burst <= data_burst + 1'b1;
            end
         end
      end
   end

   assign if_ready      = (state == RESPOND) && served_fetch;
   assign mem_ready     = (state == RESPOND) && !served_fetch;
   assign if_data       = if_ready ? response_data : '0;
   assign mem_read_data = mem_ready ? response_data : '0;
   assign stall_request = (if_request && !if_ready) || (mem_request && !mem_ready);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: drivers queue expected responses and bus
// grants, independent monitors pop and compare them as the DUT presents them.
module tb_bus_arbiter;

   localparam int MAX_BURST = 4;
   localparam int TIMEOUT   = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_request;
   logic [31:0] if_address;
   logic        if_ready;
   logic [31:0] if_data;
   logic        mem_request;
   logic        mem_write_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_byte_select;
   logic        mem_ready;
   logic [31:0] mem_read_data;
   logic        bus_chip_enable;
   logic        bus_write_enable;
   logic [31:0] bus_address;
   logic [31:0] bus_write_data;
   logic [3:0]  bus_byte_select;
   logic [31:0] bus_read_data;
   logic        bus_ready;
   logic        stall_request;
   logic        bus_error;

   bus_arbiter #(
      .MAX_DATA_BURST(MAX_BURST),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .if_request      (if_request),
      .if_address      (if_address),
      .if_ready        (if_ready),
      .if_data         (if_data),
      .mem_request     (mem_request),
      .mem_write_enable(mem_write_enable),
      .mem_address     (mem_address),
      .mem_write_data  (mem_write_data),
      .mem_byte_select (mem_byte_select),
      .mem_ready       (mem_ready),
      .mem_read_data   (mem_read_data),
      .bus_chip_enable (bus_chip_enable),
      .bus_write_enable(bus_write_enable),
      .bus_address     (bus_address),
      .bus_write_data  (bus_write_data),
      .bus_byte_select (bus_byte_select),
      .bus_read_data   (bus_read_data),
      .bus_ready       (bus_ready),
      .stall_request   (stall_request),
      .bus_error       (bus_error)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  bs;
   } bus_rec_t;

   logic [31:0] if_q[$];
   logic [31:0] mem_q[$];
   bus_rec_t    bus_q[$];
   int          compare_count  = 0;
   int          mismatch_count = 0;
   int          bus_delay      = 1;
   int          acc_cycle      = 0;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compare_count++;
      if (actual !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_if_ready"}, 32'(if_ready), 32'h0);
      check_output({tag, "_if_data"}, if_data, 32'h0);
      check_output({tag, "_mem_ready"}, 32'(mem_ready), 32'h0);
      check_output({tag, "_mem_read_data"}, mem_read_data, 32'h0);
      check_output({tag, "_bus_chip_enable"}, 32'(bus_chip_enable), 32'h0);
      check_output({tag, "_bus_write_enable"}, 32'(bus_write_enable), 32'h0);
      check_output({tag, "_bus_address"}, bus_address, 32'h0);
      check_output({tag, "_bus_write_data"}, bus_write_data, 32'h0);
      check_output({tag, "_bus_byte_select"}, 32'(bus_byte_select), 32'h0);
      check_output({tag, "_stall_request"}, 32'(stall_request), 32'h0);
      check_output({tag, "_bus_error"}, 32'(bus_error), 32'h0);
   endtask

   task automatic expect_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] bs);
      bus_rec_t rec;
      rec.we    = we;
      rec.addr  = addr;
      rec.wdata = wdata;
      rec.bs    = bs;
      bus_q.push_back(rec);
   endtask

   // Memory contents seen by the bus model
   function automatic logic [31:0] bus_memory(input logic [31:0] addr);
      if (addr == 32'h0000_0100) return 32'h2401_0001;
      return addr ^ 32'h5A5A_0000;
   endfunction

   // Called just after a rising edge; latency is the cycle index of the ready pulse.
   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_data, output int latency);
      if_q.push_back(exp_data);
      if_address = addr;
      if_request = 1'b1;
      latency    = -1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clock);
         if (if_ready) begin
            latency = c;
            break;
         end
      end
      check_output("fetch_completed", 32'(latency >= 0), 32'h1);
      @(posedge clock);
      #1;
      if_request = 1'b0;
      if_address = 32'h0;
   endtask

   task automatic do_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] bs, input logic [31:0] exp_data, output int latency);
      mem_q.push_back(exp_data);
      mem_write_enable = we;
      mem_address      = addr;
      mem_write_data   = wdata;
      mem_byte_select  = bs;
      mem_request      = 1'b1;
      latency          = -1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clock);
         if (mem_ready) begin
            latency = c;
            break;
         end
      end
      check_output("mem_completed", 32'(latency >= 0), 32'h1);
      @(posedge clock);
      #1;
      mem_request      = 1'b0;
      mem_write_enable = 1'b0;
      mem_address      = 32'h0;
      mem_write_data   = 32'h0;
      mem_byte_select  = 4'h0;
   endtask

   // Bus slave: bus_ready in access cycle bus_delay (0 = never answers)
   initial begin
      bus_ready     = 1'b0;
      bus_read_data = 32'h0;
      forever begin
         @(posedge clock);
         #1;
         acc_cycle     = bus_chip_enable ? acc_cycle + 1 : 0;
         bus_ready     = bus_chip_enable && (bus_delay != 0) && (acc_cycle == bus_delay);
         bus_read_data = bus_ready ? bus_memory(bus_address) : 32'h0;
      end
   end

   // Response monitor
   initial begin
      forever begin
         @(negedge clock);
         check_output("ready_exclusive", 32'(if_ready && mem_ready), 32'h0);
         if (if_ready) begin
            check_output("if_ready_expected", 32'(if_q.size() != 0), 32'h1);
            if (if_q.size() != 0) check_output("if_data", if_data, if_q.pop_front());
         end
         if (mem_ready) begin
            check_output("mem_ready_expected", 32'(mem_q.size() != 0), 32'h1);
            if (mem_q.size() != 0) check_output("mem_read_data", mem_read_data, mem_q.pop_front());
         end
      end
   end

   // Bus monitor: grant order, held values during access, zeros outside
   initial begin
      bus_rec_t cur;
      logic     prev_ce;
      cur     = '0;
      prev_ce = 1'b0;
      forever begin
         @(negedge clock);
         if (bus_chip_enable && !prev_ce) begin
            check_output("bus_grant_expected", 32'(bus_q.size() != 0), 32'h1);
            if (bus_q.size() != 0) cur = bus_q.pop_front();
         end
         if (bus_chip_enable) begin
            check_output("bus_write_enable", 32'(bus_write_enable), 32'(cur.we));
            check_output("bus_address", bus_address, cur.addr);
            check_output("bus_write_data", bus_write_data, cur.wdata);
            check_output("bus_byte_select", 32'(bus_byte_select), 32'(cur.bs));
         end else begin
            check_output("bus_idle_zero",
                         32'(bus_write_enable) | bus_address | bus_write_data | 32'(bus_byte_select),
                         32'h0);
         end
         prev_ce = bus_chip_enable;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int lat;
      int lat_m;
      reset            = 1'b1;
      if_request       = 1'b0;
      if_address       = 32'h0;
      mem_request      = 1'b0;
      mem_write_enable = 1'b0;
      mem_address      = 32'h0;
      mem_write_data   = 32'h0;
      mem_byte_select  = 4'h0;
      repeat (3) @(posedge clock);
      #1;
      check_all_zero("reset");
      reset = 1'b0;
      @(posedge clock);
      #1;

      $display("[TB] single fetch");
      bus_delay = 1;
      expect_bus(1'b0, 32'h100, 32'h0, 4'hF);
      do_fetch(32'h100, 32'h2401_0001, lat);
      check_output("single_fetch_latency", 32'(lat), 32'd2);

      $display("[TB] simultaneous load and fetch");
      expect_bus(1'b0, 32'h200, 32'h0, 4'hF);
      expect_bus(1'b0, 32'h104, 32'h0, 4'hF);
      fork
         do_mem(1'b0, 32'h200, 32'h0, 4'hF, 32'h5A5A_0200, lat_m);
         do_fetch(32'h104, 32'h5A5A_0104, lat);
         begin
            for (int c = 0; c < 60; c++) begin
               @(negedge clock);
               if (if_ready) begin
                  check_output("stall_at_if_ready", 32'(stall_request), 32'h0);
                  break;
               end
               check_output("stall_while_waiting", 32'(stall_request), 32'h1);
            end
         end
      join
      check_output("simul_mem_latency", 32'(lat_m), 32'd2);
      check_output("simul_fetch_latency", 32'(lat), 32'd5);

      $display("[TB] starvation bound");
      for (int i = 0; i < 4; i++) expect_bus(1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'hF);
      expect_bus(1'b0, 32'h108, 32'h0, 4'hF);
      expect_bus(1'b0, 32'h310, 32'h0, 4'hF);
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               do_mem(1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'hF, 32'h5A5A_0300 + 32'(4 * i), lat_m);
            end
         end
         do_fetch(32'h108, 32'h5A5A_0108, lat);
      join
      check_output("starve_fetch_latency", 32'(lat), 32'd14);
      check_output("starve_last_load_latency", 32'(lat_m), 32'd5);

      $display("[TB] store");
      bus_delay = 3;
      expect_bus(1'b1, 32'h400, 32'hDEAD_BEEF, 4'b0011);
      do_mem(1'b1, 32'h400, 32'hDEAD_BEEF, 4'b0011, 32'h0, lat_m);
      check_output("store_latency", 32'(lat_m), 32'd4);
      check_output("store_no_error", 32'(bus_error), 32'h0);

      $display("[TB] watchdog timeout");
      bus_delay = 0;
      expect_bus(1'b0, 32'h500, 32'h0, 4'hF);
      do_fetch(32'h500, 32'h0, lat);
      check_output("timeout_latency", 32'(lat), 32'd9);
      check_output("timeout_bus_error", 32'(bus_error), 32'h1);
      bus_delay = 1;
      expect_bus(1'b0, 32'h100, 32'h0, 4'hF);
      do_fetch(32'h100, 32'h2401_0001, lat);
      check_output("bus_error_sticky", 32'(bus_error), 32'h1);

      $display("[TB] reset during data access");
      bus_delay = 0;
      expect_bus(1'b0, 32'h600, 32'h0, 4'hF);
      mem_write_enable = 1'b0;
      mem_address      = 32'h600;
      mem_byte_select  = 4'hF;
      mem_request      = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check_output("mid_access_active", 32'(bus_chip_enable), 32'h1);
      reset           = 1'b1;
      mem_request     = 1'b0;
      mem_address     = 32'h0;
      mem_byte_select = 4'h0;
      @(posedge clock);
      #1;
      check_all_zero("mid_reset");
      reset = 1'b0;
      repeat (4) begin
         @(negedge clock);
         check_output("no_mem_ready_after_reset", 32'(mem_ready), 32'h0);
      end
      @(posedge clock);
      #1;
      bus_delay = 1;
      expect_bus(1'b0, 32'h100, 32'h0, 4'hF);
      do_fetch(32'h100, 32'h2401_0001, lat);
      check_output("post_reset_fetch_latency", 32'(lat), 32'd2);

      repeat (2) @(posedge clock);
      check_output("if_queue_drained", 32'(if_q.size()), 32'h0);
      check_output("mem_queue_drained", 32'(mem_q.size()), 32'h0);
      check_output("bus_queue_drained", 32'(bus_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares the single external memory bus between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the five-stage pipeline. It serialises requests through a small state machine and returns a one-cycle ready pulse with registered read data to the granted requester. It exports a combinational stall request to the pipeline latches and applies data-first priority with a bounded fetch-starvation guarantee. A bus watchdog aborts accesses that never complete.

## Interface
Parameters:
- MAX_DATA_BURST, 4: consecutive data grants allowed while a fetch is waiting (≥1).
- TIMEOUT_CYCLES, 255: bus cycles before abort; 0 disables the watchdog.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- if_request  in  1  fetch request; held stable until if_ready.
- if_address  in  32  fetch address.
- if_ready  out  1  one-cycle completion pulse for the fetch.
- if_data  out  32  fetched word; valid while if_ready is high.
- mem_request  in  1  data request; held stable until mem_ready.
- mem_write_enable  in  1  1 = store, 0 = load.
- mem_address  in  32  data address.
- mem_write_data  in  32  store data.
- mem_byte_select  in  4  byte lanes.
- mem_ready  out  1  one-cycle completion pulse for the data access.
- mem_read_data  out  32  load data; 0 for stores.
- bus_chip_enable  out  1  bus access active.
- bus_write_enable  out  1  bus store.
- bus_address  out  32  bus address.
- bus_write_data  out  32  bus store data.
- bus_byte_select  out  4  bus lanes; 4'b1111 for fetches.
- bus_read_data  in  32  bus read data; sampled when bus_ready is high.
- bus_ready  in  1  bus completion; may arrive in the first access cycle.
- stall_request  out  1  (if_request & ~if_ready) | (mem_request & ~mem_ready).
- bus_error  out  1  sticky watchdog flag; cleared only by reset.

## Operation
- States: IDLE, IF_ACCESS, MEM_ACCESS, RESPOND.
- **IDLE → grant selection:**
  - mem_request only → MEM_ACCESS.
  - if_request only → IF_ACCESS.
  - Both requests → MEM_ACCESS, unless data_burst == MAX_DATA_BURST, in which case IF_ACCESS.
- **Bus outputs:** registered on entry to an ACCESS state and held constant through that state. Every bus output is 0 outside the ACCESS states.
- **data_burst counter:**
  - Increments on each data grant made while if_request is high; saturates at MAX_DATA_BURST.
  - Clears on any fetch grant.
  - Clears on a data grant made while if_request is low.
- **ACCESS state:**
  - bus_ready high → capture bus_read_data (forced to 0 for stores) into the response register, move to RESPOND.
  - Watchdog count reaches TIMEOUT_CYCLES → response data 0, set bus_error, move to RESPOND.
  - Watchdog count resets on ACCESS entry.
- **RESPOND:** pulse the granted requester's ready for exactly one cycle, then → IDLE. The requester must drop or change its request in the cycle after ready. IDLE re-arbitrates from fresh inputs.
- **Reset:** state → IDLE, counters → 0, bus_error → 0. Any in-flight access is abandoned without a response.

## Timing
- Reset value of every output is 0. The one exception is stall_request, which follows its combinational equation.
- Request seen in IDLE at cycle 0 → bus_chip_enable high in cycle 1.
- bus_ready in cycle k (k ≥ 1) → requester ready and data in cycle k+1 → IDLE in cycle k+2.
- Minimum latency is 2 cycles (request → ready). Peak throughput is one access per 3 cycles.
- The watchdog aborts in the ACCESS cycle where count == TIMEOUT_CYCLES. The ready pulse follows one cycle later.
- if_ready and mem_ready are never high in the same cycle.
- A request arriving while another access is in progress waits in IDLE arbitration. stall_request stays high throughout the wait.
- If bus_ready and the timeout coincide in the same cycle, bus_ready wins and bus_error is not set.

## Structure
- The shared package holds:
  - the state encoding (IDLE, IF_ACCESS, MEM_ACCESS, RESPOND);
  - the bus byte-select constant for a full-word fetch (4'b1111);
  - the default MAX_DATA_BURST and TIMEOUT_CYCLES values.
- One sub-module, bus_watchdog, contains the timeout counter. Its ports are clock, reset, start, done, and timeout.
- The arbiter FSM, burst counter and response registers live in bus_arbiter.

## Test plan
- Single fetch: if_request with address 0x100, bus_ready in the first access cycle with data 0x24010001 → bus_address 0x100 in cycle 1; if_ready with if_data 0x24010001 in cycle 2.
- Simultaneous requests: load at 0x200 and fetch at 0x104 → data granted first; fetch granted after mem_ready; stall_request stays high until if_ready.
- Starvation bound: mem_request held continuously with MAX_DATA_BURST = 4 and if_request high → exactly 4 data grants, then one fetch grant.
- Store: mem_write_enable = 1, byte_select 4'b0011, data 0xDEADBEEF, bus_ready after 3 cycles → bus outputs match the request; mem_ready pulses with mem_read_data = 0.
- Timeout: TIMEOUT_CYCLES = 8, bus_ready never asserted → abort in the 8th access cycle; ready pulse with data 0; bus_error stays 1 until reset.
- Reset mid-access: reset during MEM_ACCESS → all outputs 0 the next cycle; no mem_ready pulse; fresh arbitration afterwards.
